nic_flit_injector: RTL
======================

Name: nic_flit_injector

Overview:
- Local-port network interface that feeds router_top's local input port (input_data[LOCAL]/input_valid[LOCAL]).
- Accepts packet headers and payload words from the core over valid/ready handshakes and segments each packet into head/body/tail flits.
- Emits at most one flit per cycle, gated by a credit counter that mirrors free local-port buffer slots in the router.
- Credits are returned one per pulse on credit_increment.

Parameters:
- FLIT_W, `FLIT_DATA_WIDTH, flit width in bits.
- DEST_BITS, 3, destination router id width.
- LEN_BITS, 4, body-flit count width (0..2^LEN_BITS-1 body flits).
- CREDITS, 16, initial and maximum credit count (NUM_VC * VC buffer depth).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- hdr_valid  in  1  header offered.
- hdr_ready  out  1  header accepted this cycle when hdr_valid is also high.
- hdr_dest  in  DEST_BITS  destination id.
- hdr_len  in  LEN_BITS  number of body flits following the head.
- pl_valid  in  1  payload word offered.
- pl_ready  out  1  payload word accepted this cycle when pl_valid is also high.
- pl_data  in  FLIT_W-2  payload word.
- credit_increment  in  1  one credit returned by the router.
- flit_data  out  FLIT_W  flit to the router local input.
- flit_valid  out  1  flit_data valid, one-cycle pulse per flit.
- credit_count  out  $clog2(CREDITS+1)  current credits.
- credit_overflow  out  1  sticky error flag.

Behaviour:
- Flit layout: [FLIT_W-1:FLIT_W-2] is the type: 00 HEAD_TAIL, 01 HEAD, 10 BODY, 11 TAIL.
  - Head flit: [FLIT_W-3 -: DEST_BITS] = dest; [LEN_BITS-1:0] = len; all other bits 0.
  - Body/tail flit: [FLIT_W-3:0] = payload word.
- Reset (asynchronous, any time, including mid-packet):
  - State goes to IDLE.
  - flit_valid=0, flit_data=0, hdr_ready=0, pl_ready=0.
  - credit_count=CREDITS, credit_overflow=0, remaining-length register=0.
- can_send = (credit_count != 0). It uses the registered count only; an increment arriving in the same cycle is not usable until the next cycle.
- FSM:
  - IDLE: hdr_ready = can_send.
    - On hdr_valid&&hdr_ready with len==0: register a HEAD_TAIL flit; stay in IDLE.
    - On hdr_valid&&hdr_ready with len>0: register a HEAD flit, load rem=len, go to BODY.
  - BODY: pl_ready = can_send; hdr_ready=0.
    - On pl_valid&&pl_ready with rem>1: register a BODY flit, rem--.
    - On pl_valid&&pl_ready with rem==1: register a TAIL flit, go to IDLE.
    - Payload stalls (pl_valid=0) hold the state with no flit emitted.
- Output timing: flit_data/flit_valid are registered. An accept in cycle N gives flit_valid=1 in cycle N+1. flit_valid=0 in any cycle with no accept; flit_data holds its last value.
- Credits:
  - A send (any accept) decrements; credit_increment increments.
  - Both in the same cycle: count unchanged.
  - A send never occurs at 0 because it is gated by can_send.
  - Increment at CREDITS with no send: count saturates at CREDITS and credit_overflow is set sticky until reset.
- Back-to-back: a HEAD_TAIL accept in IDLE may be followed by another header accept in the next cycle, giving one flit per cycle sustained.
- Throughput bound: at most CREDITS flits outstanding without returned credits.
- hdr_dest/hdr_len/pl_data are sampled only on handshake cycles; values at other times are don't-care.

Decomposition:
- Shared package (nic_pkg), for reuse by a future ejector:
  - Flit type enum (FT_HEAD_TAIL, FT_HEAD, FT_BODY, FT_TAIL).
  - FSM state enum (S_IDLE, S_BODY).
  - Field-offset localparams (TYPE_MSB, DEST_MSB).
- One sub-module, nic_credit_counter: a saturating up/down counter with ports inc, dec, count, overflow, parameter MAX.
- The FSM and flit formatting stay in the top module.

Test Plan:
- Reset then idle:
  - Release reset with no stimulus → credit_count=16, flit_valid=0, hdr_ready=1.
  - Assert reset mid-BODY → next cycle state IDLE, credit_count=16, flit_valid=0.
- Single-flit packet:
  - Stimulus: hdr_dest=5, hdr_len=0 accepted at cycle N.
  - Response: cycle N+1 flit_valid=1, type=00, dest field=5.
  - Response: credit_count=15, hdr_ready stays 1.
- Three-flit packet:
  - Stimulus: hdr_len=2, then payloads 0xA5, 0x3C.
  - Response: flits HEAD(len=2), BODY(0xA5), TAIL(0x3C) on consecutive cycles.
  - Response: hdr_ready=0 while in BODY; credit_count=13.
- Credit exhaustion:
  - Stimulus: inject 16 HEAD_TAIL packets with no credit return.
  - Response: hdr_ready=0 once credit_count=0, and no 17th flit.
  - Stimulus: one credit_increment pulse.
  - Response: next cycle hdr_ready=1, and exactly one more flit.
- Simultaneous events:
  - Stimulus: at credit_count=7, a send and credit_increment in the same cycle.
  - Response: count stays 7.
  - Stimulus: at credit_count=0, credit_increment together with hdr_valid.
  - Response: header not accepted that cycle; accepted the following cycle.
- Overflow:
  - Stimulus: credit_increment at credit_count=16.
  - Response: count stays 16 and credit_overflow=1, remaining 1 through subsequent traffic until reset.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared NIC definitions: flit type encoding, injector FSM states and flit field offsets.
package nic_pkg;

  localparam int unsigned FLIT_DATA_WIDTH = 32;

  // Field offsets for the default flit width
  localparam int unsigned TYPE_MSB = FLIT_DATA_WIDTH - 1;
  localparam int unsigned DEST_MSB = FLIT_DATA_WIDTH - 3;

  typedef enum logic [1:0] {
    FT_HEAD_TAIL = 2'b00,
    FT_HEAD      = 2'b01,
    FT_BODY      = 2'b10,
    FT_TAIL      = 2'b11
  } flit_type_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BODY = 1'b1
  } state_e;

endpackage

// File: rtl/nic_credit_counter.sv
// Saturating up/down credit counter; an increment at MAX without a decrement sets a sticky overflow.
module nic_credit_counter #(
  parameter int unsigned MAX = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inc,
  input  logic                         dec,
  output logic [$clog2(MAX+1)-1:0]     count,
  output logic                         overflow
);

  localparam int unsigned CW = $clog2(MAX + 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= CW'(MAX);
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count == CW'(MAX)) overflow <= 1'b1;
      else                   count    <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/nic_flit_injector.sv
// Local-port network interface: segments core packets into head/body/tail flits,
// one flit per cycle, gated by credits mirroring the router's local buffer space.
module nic_flit_injector
  import nic_pkg::*;
#(
  parameter int unsigned FLIT_W    = FLIT_DATA_WIDTH,
  parameter int unsigned DEST_BITS = 3,
  parameter int unsigned LEN_BITS  = 4,
  parameter int unsigned CREDITS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hdr_valid,
  output logic                           hdr_ready,
  input  logic [DEST_BITS-1:0]           hdr_dest,
  input  logic [LEN_BITS-1:0]            hdr_len,
  input  logic                           pl_valid,
  output logic                           pl_ready,
  input  logic [FLIT_W-3:0]              pl_data,
  input  logic                           credit_increment,
  output logic [FLIT_W-1:0]              flit_data,
  output logic                           flit_valid,
  output logic [$clog2(CREDITS+1)-1:0]   credit_count,
  output logic                           credit_overflow
);

  localparam int unsigned FT_MSB = FLIT_W - 1;
  localparam int unsigned FD_MSB = FLIT_W - 3;

  state_e              r_state, w_state_nxt;
  logic [LEN_BITS-1:0] r_rem, w_rem_nxt;
  logic [FLIT_W-1:0]   r_flit_data, w_flit_nxt;
  logic                r_flit_valid;
  logic                w_send, w_can_send, w_hdr_ready, w_pl_ready;

  nic_credit_counter #(.MAX(CREDITS)) u_credits (
    .clk      (clk),
    .reset    (reset),
    .inc      (credit_increment),
    .dec      (w_send),
    .count    (credit_count),
    .overflow (credit_overflow)
  );

  // Registered count only: a credit returned this cycle is usable next cycle
  assign w_can_send = (credit_count != '0);

  // Next-state, handshake and flit formatting
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_flit_nxt  = r_flit_data;
    w_send      = 1'b0;
    w_hdr_ready = 1'b0;
    w_pl_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_hdr_ready = w_can_send;
        if (hdr_valid && w_can_send) begin
          w_send                         = 1'b1;
          w_flit_nxt                     = '0;
          w_flit_nxt[FD_MSB -: DEST_BITS] = hdr_dest;
          w_flit_nxt[LEN_BITS-1:0]       = hdr_len;
          if (hdr_len == '0) begin
            w_flit_nxt[FT_MSB -: 2] = FT_HEAD_TAIL;
          end else begin
            w_flit_nxt[FT_MSB -: 2] = FT_HEAD;
            w_rem_nxt               = hdr_len;
            w_state_nxt             = S_BODY;
          end
        end
      end
      S_BODY: begin
        w_pl_ready = w_can_send;
        if (pl_valid && w_can_send) begin
          w_send    = 1'b1;
          w_rem_nxt = r_rem - 1'b1;
          if (r_rem > LEN_BITS'(1)) begin
            w_flit_nxt = {FT_BODY, pl_data};
          end else begin
            w_flit_nxt  = {FT_TAIL, pl_data};
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rem        <= '0;
      r_flit_data  <= '0;
      r_flit_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rem        <= w_rem_nxt;
      r_flit_data  <= w_flit_nxt;
      r_flit_valid <= w_send;
    end
  end

  // Readies are held low while reset is asserted
  assign hdr_ready  = w_hdr_ready & ~reset;
  assign pl_ready   = w_pl_ready & ~reset;
  assign flit_data  = r_flit_data;
  assign flit_valid = r_flit_valid;

endmodule
